// File: rtl/hazard_ctrl.sv
// Stall/bubble controller for the 5-stage pipeline: load-use, branch-operand and MDU-busy hazards.
// Optional stall-cycle performance counter enabled by defining HAZARD_PERF_EN.
module hazard_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_d,
  input  logic        use_rs_d,
  input  logic        use_rt_d,
  input  logic        branch_d,
  input  logic        mdu_use_d,
  input  logic [4:0]  wba_e,
  input  logic        memread_e,
  input  logic [4:0]  wba_m,
  input  logic        memread_m,
  input  logic        mdu_start_e,
  input  logic        mdu_div_e,
  output logic        pc_en,
  output logic        fd_en,
  output logic        de_clr,
  output logic        stall,
  output logic        mdu_busy,
  output logic [31:0] stall_cnt
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_LAT - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;

  logic [4:0] rs_d, rt_d;
  logic       lu, br, md;
  logic       unused_instr;

  assign rs_d         = instr_d[25:21];
  assign rt_d         = instr_d[20:16];
  assign unused_instr = ^{instr_d[31:26], instr_d[15:0]};

  function automatic logic hit(input logic [4:0] r, input logic [4:0] w);
    return (r != '0) && (r == w);
  endfunction

  assign lu = memread_e && ((use_rs_d && hit(rs_d, wba_e)) ||
                            (use_rt_d && hit(rt_d, wba_e)));

  // Branches resolve in D, so any pending ALU result in E or load in M blocks them.
  assign br = branch_d &&
              ((use_rs_d && (hit(rs_d, wba_e) || (memread_m && hit(rs_d, wba_m)))) ||
               (use_rt_d && (hit(rt_d, wba_e) || (memread_m && hit(rt_d, wba_m)))));

  assign mdu_busy = mdu_start_e | (state == BUSY);
  assign md       = mdu_use_d && mdu_busy;

  assign stall  = lu | br | md;
  assign pc_en  = ~stall;
  assign fd_en  = ~stall;
  assign de_clr = stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (mdu_start_e) begin
      cnt_nx   = mdu_div_e ? DIV_LD : MULT_LD;
      state_nx = (cnt_nx != '0) ? BUSY : IDLE;
    end else begin
      case (state)
        BUSY: begin
          if (cnt <= CNT_W'(1)) begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt - CNT_W'(1);
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = cnt;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      perf_q <= '0;
    else if (stall)
      perf_q <= perf_q + 32'd1;
  end

  assign stall_cnt = perf_q;
`else
  assign stall_cnt = '0;
`endif

endmodule
